// File: rtl/regfile_mp_pkg.sv
// -----------------------------------------------------------------------------
// regfile_mp_pkg
//   Shared constants and types for the multi-port integer register file.
//   REG_LEN / REG_ADDR_LEN / REG_NUM are the default geometry (32 x 32-bit,
//   5-bit addresses). rd_src_e names the source a read port forwards.
// -----------------------------------------------------------------------------
package regfile_mp_pkg;

  localparam int REG_LEN      = 32;
  localparam int REG_ADDR_LEN = 5;
  localparam int REG_NUM      = 32;

  // Where a read port takes its data/busy from.
  typedef enum logic [1:0] {
    SRC_OFF    = 2'd0,  // reset or port disabled: zero, not busy
    SRC_ZERO   = 2'd1,  // x0: zero, not busy
    SRC_BYPASS = 2'd2,  // same-cycle write forwarded, not busy
    SRC_ARRAY  = 2'd3   // architectural array plus scoreboard bit
  } rd_src_e;

endpackage

// File: rtl/regfile_mp_rd_port.sv
// -----------------------------------------------------------------------------
// regfile_mp_rd_port
//   One combinational read port of regfile_mp. Chooses between zero,
//   same-cycle write bypass and the stored array value, and qualifies the
//   scoreboard busy bit accordingly.
// Ports:
//   rst       in  1            reset; forces zero data / not busy
//   rd_en     in  1            port enable
//   rd_addr   in  ADDR_W       register being read
//   wr_en     in  NWR          write-port enables (bypass candidates)
//   wr_addr   in  NWR*ADDR_W   write addresses
//   wr_data   in  NWR*XLEN     write data
//   arr_data  in  XLEN         regs[rd_addr] from the array
//   arr_busy  in  1            busy[rd_addr] from the scoreboard
//   rd_data   out XLEN         read data
//   rd_busy   out 1            pending producer on rd_addr
// -----------------------------------------------------------------------------
module regfile_mp_rd_port
  import regfile_mp_pkg::*;
#(
  parameter int XLEN   = REG_LEN,
  parameter int ADDR_W = REG_ADDR_LEN,
  parameter int NWR    = 2
) (
  input  logic                  rst,
  input  logic                  rd_en,
  input  logic [ADDR_W-1:0]     rd_addr,
  input  logic [NWR-1:0]        wr_en,
  input  logic [NWR*ADDR_W-1:0] wr_addr,
  input  logic [NWR*XLEN-1:0]   wr_data,
  input  logic [XLEN-1:0]       arr_data,
  input  logic                  arr_busy,
  output logic [XLEN-1:0]       rd_data,
  output logic                  rd_busy
);

  logic            hit_s;
  logic [XLEN-1:0] byp_data_s;
  rd_src_e         src_s;

  // Bypass search; scanning upward lets the youngest hitting port win.
  always_comb begin
    logic hit_i;
    hit_i      = 1'b0;
    hit_s      = 1'b0;
    byp_data_s = {XLEN{1'b0}};
    for (int i = 0; i < NWR; i++) begin
      hit_i      = wr_en[i] && (wr_addr[i*ADDR_W +: ADDR_W] == rd_addr);
      hit_s      = hit_s | hit_i;
      byp_data_s = hit_i ? wr_data[i*XLEN +: XLEN] : byp_data_s;
    end
  end

  // Source selection, first matching rule wins.
  always_comb begin
    if (rst) begin
      src_s = SRC_OFF;
    end else if (!rd_en) begin
      src_s = SRC_OFF;
    end else if (rd_addr == {ADDR_W{1'b0}}) begin
      src_s = SRC_ZERO;
    end else if (hit_s) begin
      src_s = SRC_BYPASS;
    end else begin
      src_s = SRC_ARRAY;
    end
  end

  // Output mux; a bypassed value is by definition no longer pending.
  always_comb begin
    rd_data = {XLEN{1'b0}};
    rd_busy = 1'b0;
    case (src_s)
      SRC_BYPASS: begin
        rd_data = byp_data_s;
        rd_busy = 1'b0;
      end
      SRC_ARRAY: begin
        rd_data = arr_data;
        rd_busy = arr_busy;
      end
      default: begin
        rd_data = {XLEN{1'b0}};
        rd_busy = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/regfile_mp.sv
// -----------------------------------------------------------------------------
// regfile_mp
//   Multi-port integer register file for the dual-issue core: NRD
//   combinational read ports with same-cycle write bypass, NWR synchronous
//   write ports (higher index = younger, wins collisions), x0 hardwired to
//   zero, and a per-register busy scoreboard (set at issue, cleared at
//   writeback, cleared wholesale by flush) with a registered busy count.
// Ports:
//   clk       in  1            clock
//   rst       in  1            asynchronous active-high reset
//   rd_en     in  NRD          read-port enables
//   rd_addr   in  NRD*ADDR_W   read addresses, port p at [p*ADDR_W +: ADDR_W]
//   rd_data   out NRD*XLEN     read data, port p at [p*XLEN +: XLEN]
//   rd_busy   out NRD          pending producer on rd_addr[p]
//   wr_en     in  NWR          write-port enables
//   wr_addr   in  NWR*ADDR_W   write addresses
//   wr_data   in  NWR*XLEN     write data
//   iss_en    in  NWR          issue enables (mark iss_addr[i] busy)
//   iss_addr  in  NWR*ADDR_W   destinations being issued
//   flush     in  1            clear every busy bit, data untouched
//   busy_cnt  out ADDR_W+1     registered number of busy registers
// -----------------------------------------------------------------------------
module regfile_mp
  import regfile_mp_pkg::*;
#(
  parameter int XLEN   = REG_LEN,
  parameter int NREGS  = REG_NUM,
  parameter int ADDR_W = REG_ADDR_LEN,
  parameter int NRD    = 2,
  parameter int NWR    = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NRD-1:0]        rd_en,
  input  logic [NRD*ADDR_W-1:0] rd_addr,
  output logic [NRD*XLEN-1:0]   rd_data,
  output logic [NRD-1:0]        rd_busy,
  input  logic [NWR-1:0]        wr_en,
  input  logic [NWR*ADDR_W-1:0] wr_addr,
  input  logic [NWR*XLEN-1:0]   wr_data,
  input  logic [NWR-1:0]        iss_en,
  input  logic [NWR*ADDR_W-1:0] iss_addr,
  input  logic                  flush,
  output logic [ADDR_W:0]       busy_cnt
);

  logic [XLEN-1:0]  regs_r [NREGS];
  logic [NREGS-1:0] busy_r;
  logic [NREGS-1:0] busy_nxt_s;
  logic [ADDR_W:0]  cnt_nxt_s;

  // Data array; ascending scan makes the youngest port's write land last.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < NREGS; r++) begin
        regs_r[r] <= {XLEN{1'b0}};
      end
    end else begin
      for (int i = 0; i < NWR; i++) begin
        if (wr_en[i] && (wr_addr[i*ADDR_W +: ADDR_W] != {ADDR_W{1'b0}})) begin
          regs_r[wr_addr[i*ADDR_W +: ADDR_W]] <= wr_data[i*XLEN +: XLEN];
        end
      end
    end
  end

  // Next busy state: flush > issue > writeback > hold. Issue beats a
  // writeback to the same register because the new producer supersedes it.
  always_comb begin
    logic iss_hit;
    logic wr_hit;
    iss_hit    = 1'b0;
    wr_hit     = 1'b0;
    busy_nxt_s = busy_r;
    for (int r = 1; r < NREGS; r++) begin
      iss_hit = 1'b0;
      wr_hit  = 1'b0;
      for (int i = 0; i < NWR; i++) begin
        iss_hit = iss_hit | (iss_en[i] && (iss_addr[i*ADDR_W +: ADDR_W] == ADDR_W'(r)));
        wr_hit  = wr_hit  | (wr_en[i]  && (wr_addr[i*ADDR_W +: ADDR_W]  == ADDR_W'(r)));
      end
      if (flush) begin
        busy_nxt_s[r] = 1'b0;
      end else if (iss_hit) begin
        busy_nxt_s[r] = 1'b1;
      end else if (wr_hit) begin
        busy_nxt_s[r] = 1'b0;
      end else begin
        busy_nxt_s[r] = busy_r[r];
      end
    end
    // x0 never has a producer.
    busy_nxt_s[0] = 1'b0;
  end

  // Popcount of the next busy state so busy_cnt tracks busy_r edge for edge.
  always_comb begin
    cnt_nxt_s = {(ADDR_W+1){1'b0}};
    for (int r = 0; r < NREGS; r++) begin
      cnt_nxt_s = cnt_nxt_s + (ADDR_W+1)'(busy_nxt_s[r]);
    end
  end

  // Scoreboard and busy-count registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_r   <= {NREGS{1'b0}};
      busy_cnt <= {(ADDR_W+1){1'b0}};
    end else begin
      busy_r   <= busy_nxt_s;
      busy_cnt <= cnt_nxt_s;
    end
  end

  // One read-port instance per port; each sees the current array/scoreboard
  // (never same-cycle issue) plus all write ports for bypass.
  for (genvar p = 0; p < NRD; p++) begin : g_rd
    logic [ADDR_W-1:0] addr_s;
    assign addr_s = rd_addr[p*ADDR_W +: ADDR_W];

    regfile_mp_rd_port #(
      .XLEN   (XLEN),
      .ADDR_W (ADDR_W),
      .NWR    (NWR)
    ) u_rd_port (
      .rst      (rst),
      .rd_en    (rd_en[p]),
      .rd_addr  (addr_s),
      .wr_en    (wr_en),
      .wr_addr  (wr_addr),
      .wr_data  (wr_data),
      .arr_data (regs_r[addr_s]),
      .arr_busy (busy_r[addr_s]),
      .rd_data  (rd_data[p*XLEN +: XLEN]),
      .rd_busy  (rd_busy[p])
    );
  end

endmodule

// File: tb/tb_regfile_mp.sv
// -----------------------------------------------------------------------------
// tb_regfile_mp
//   Drives directed and random traffic into regfile_mp. Each cycle the driver
//   pushes the expected read/busy/count view (from an array-based reference
//   model) into a queue; an independent monitor pops and compares it against
//   the DUT outputs mid-cycle.
// -----------------------------------------------------------------------------
module tb_regfile_mp;

  localparam int XLEN   = 32;
  localparam int NREGS  = 32;
  localparam int ADDR_W = 5;
  localparam int NRD    = 2;
  localparam int NWR    = 2;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NRD-1:0]        rd_en;
  logic [NRD*ADDR_W-1:0] rd_addr;
  logic [NRD*XLEN-1:0]   rd_data;
  logic [NRD-1:0]        rd_busy;
  logic [NWR-1:0]        wr_en;
  logic [NWR*ADDR_W-1:0] wr_addr;
  logic [NWR*XLEN-1:0]   wr_data;
  logic [NWR-1:0]        iss_en;
  logic [NWR*ADDR_W-1:0] iss_addr;
  logic                  flush;
  logic [ADDR_W:0]       busy_cnt;

  regfile_mp #(
    .XLEN(XLEN), .NREGS(NREGS), .ADDR_W(ADDR_W), .NRD(NRD), .NWR(NWR)
  ) dut (
    .clk(clk), .rst(rst),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .iss_en(iss_en), .iss_addr(iss_addr), .flush(flush),
    .busy_cnt(busy_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [NRD*XLEN-1:0] data;
    logic [NRD-1:0]      busy;
    int                  cnt;
    int                  step;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   step_no = 0;

  // Reference model: architectural contents and pending-producer flags.
  logic [XLEN-1:0] m_regs [NREGS];
  bit              m_busy [NREGS];

  task automatic idle();
    rd_en = '0; rd_addr = '0;
    wr_en = '0; wr_addr = '0; wr_data = '0;
    iss_en = '0; iss_addr = '0;
    flush = 1'b0;
  endtask

  task automatic set_rd(input int p, input int a);
    rd_en[p] = 1'b1;
    rd_addr[p*ADDR_W +: ADDR_W] = ADDR_W'(a);
  endtask

  task automatic set_wr(input int i, input int a, input logic [XLEN-1:0] d);
    wr_en[i] = 1'b1;
    wr_addr[i*ADDR_W +: ADDR_W] = ADDR_W'(a);
    wr_data[i*XLEN +: XLEN] = d;
  endtask

  task automatic set_iss(input int i, input int a);
    iss_en[i] = 1'b1;
    iss_addr[i*ADDR_W +: ADDR_W] = ADDR_W'(a);
  endtask

  function automatic int pick();
    if ($urandom_range(0, 1) == 0) return int'($urandom_range(0, 7));
    return int'($urandom_range(0, NREGS - 1));
  endfunction

  // What the outputs must show right now, given current inputs and model.
  function automatic exp_t predict();
    exp_t e;
    e.data = '0;
    e.busy = '0;
    e.cnt  = 0;
    e.step = step_no;
    if (!rst) begin
      for (int p = 0; p < NRD; p++) begin
        int a;
        bit hit;
        a = int'(rd_addr[p*ADDR_W +: ADDR_W]);
        hit = 1'b0;
        if (rd_en[p] && a != 0) begin
          for (int i = 0; i < NWR; i++) begin
            if (wr_en[i] && int'(wr_addr[i*ADDR_W +: ADDR_W]) == a) begin
              e.data[p*XLEN +: XLEN] = wr_data[i*XLEN +: XLEN];
              hit = 1'b1;
            end
          end
          if (!hit) begin
            e.data[p*XLEN +: XLEN] = m_regs[a];
            e.busy[p] = m_busy[a];
          end
        end
      end
      for (int r = 0; r < NREGS; r++) e.cnt += int'(m_busy[r]);
    end
    return e;
  endfunction

  // Clock-edge update of the model, applied as ordered events: writes,
  // then writeback clears, then issues, then flush.
  task automatic model_edge();
    if (rst) begin
      for (int r = 0; r < NREGS; r++) begin
        m_regs[r] = '0;
        m_busy[r] = 1'b0;
      end
    end else begin
      for (int i = 0; i < NWR; i++) begin
        int a;
        a = int'(wr_addr[i*ADDR_W +: ADDR_W]);
        if (wr_en[i] && a != 0) m_regs[a] = wr_data[i*XLEN +: XLEN];
        if (wr_en[i]) m_busy[a] = 1'b0;
      end
      for (int i = 0; i < NWR; i++) begin
        int a;
        a = int'(iss_addr[i*ADDR_W +: ADDR_W]);
        if (iss_en[i] && a != 0) m_busy[a] = 1'b1;
      end
      if (flush) begin
        for (int r = 0; r < NREGS; r++) m_busy[r] = 1'b0;
      end
    end
  endtask

  // Inputs are set at a negedge; record the expectation, pass one edge.
  task automatic cycle();
    exp_q.push_back(predict());
    @(posedge clk);
    model_edge();
    @(negedge clk);
    step_no++;
  endtask

  // Monitor: compares the DUT against queued expectations 2 time units after
  // the negedge on which the stimulus was applied.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      while (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        for (int p = 0; p < NRD; p++) begin
          checks++;
          if (rd_data[p*XLEN +: XLEN] !== e.data[p*XLEN +: XLEN]) begin
            errors++;
            $display("FAIL rd_data[%0d] step %0d: got %h expected %h", p, e.step,
                     rd_data[p*XLEN +: XLEN], e.data[p*XLEN +: XLEN]);
          end
        end
        checks++;
        if (rd_busy !== e.busy) begin
          errors++;
          $display("FAIL rd_busy step %0d: got %b expected %b", e.step, rd_busy, e.busy);
        end
        checks++;
        if (busy_cnt !== (ADDR_W+1)'(e.cnt)) begin
          errors++;
          $display("FAIL busy_cnt step %0d: got %0d expected %0d", e.step, busy_cnt, e.cnt);
        end
      end
    end
  end

  initial begin : driver
    for (int r = 0; r < NREGS; r++) begin
      m_regs[r] = '0;
      m_busy[r] = 1'b0;
    end
    idle();
    rst = 1'b1;
    @(negedge clk);
    set_rd(0, 5); set_rd(1, 9);
    cycle();
    rst = 1'b0;

    // Write then read; x0 writes dropped.
    idle(); set_wr(0, 5, 32'hDEADBEEF); cycle();
    idle(); set_rd(0, 5); cycle();
    idle(); set_wr(0, 0, 32'h0000_1234); set_rd(1, 0); cycle();
    idle(); set_rd(0, 0); set_rd(1, 5); cycle();

    // Bypass with write collision: port 1 wins.
    idle(); set_wr(0, 7, 32'h11); set_wr(1, 7, 32'h22); set_rd(0, 7); cycle();
    idle(); set_rd(0, 7); cycle();

    // Scoreboard: issue invisible same cycle, busy next cycle, cleared by write.
    idle(); set_iss(0, 3); set_rd(0, 3); cycle();
    idle(); set_rd(0, 3); cycle();
    idle(); set_wr(0, 3, 32'h5); set_rd(0, 3); cycle();
    idle(); set_rd(1, 3); cycle();

    // Issue beats writeback on the same register.
    idle(); set_iss(1, 9); cycle();
    idle(); set_wr(0, 9, 32'hAA); set_iss(0, 9); set_rd(0, 9); cycle();
    idle(); set_rd(0, 9); cycle();
    idle(); set_wr(1, 9, 32'hBB); cycle();

    // Flush with a concurrent write.
    idle(); set_iss(0, 1); set_iss(1, 2); cycle();
    idle(); set_iss(0, 4); set_rd(0, 1); set_rd(1, 2); cycle();
    idle(); flush = 1'b1; set_wr(1, 2, 32'h99); set_rd(0, 2); set_rd(1, 4); cycle();
    idle(); set_rd(0, 2); set_rd(1, 4); cycle();
    idle(); set_rd(0, 1); cycle();

    // Random traffic, including occasional reset and flush.
    for (int n = 0; n < 600; n++) begin
      idle();
      rst = ($urandom_range(0, 99) == 0);
      for (int p = 0; p < NRD; p++)
        if ($urandom_range(0, 3) != 0) set_rd(p, pick());
      for (int i = 0; i < NWR; i++)
        if ($urandom_range(0, 2) == 0) set_wr(i, pick(), $urandom());
      for (int i = 0; i < NWR; i++)
        if ($urandom_range(0, 3) == 0) set_iss(i, pick());
      flush = ($urandom_range(0, 29) == 0);
      cycle();
    end
    rst = 1'b0;

    // Populate and mark busy, then an async reset pulse, then read everything.
    idle(); set_wr(0, 12, 32'hCAFE_F00D); set_iss(0, 13); set_iss(1, 14); cycle();
    idle(); set_rd(0, 12); set_rd(1, 13); cycle();
    idle(); rst = 1'b1; set_rd(0, 12); set_rd(1, 13); cycle();
    rst = 1'b0;
    for (int a = 1; a < NREGS; a += 2) begin
      idle();
      set_rd(0, a);
      if (a + 1 < NREGS) set_rd(1, a + 1);
      cycle();
    end

    idle();
    #3;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
